// File: rtl/sub_arb.sv
// Two-requester subtractor sharing one adder and one result register, round-robin arbitrated.
// Define SUB_ARB_LOCK_EN to hold the grant on a requester until its eot=1 transfer is accepted.
module sub_arb #(
  parameter int unsigned W      = 16,
  parameter bit          SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_dvalid,
  output logic           req0_dready,
  input  logic [2*W-1:0] req0_data,
  input  logic           req0_eot,
  input  logic           req1_dvalid,
  output logic           req1_dready,
  input  logic [2*W-1:0] req1_data,
  input  logic           req1_eot,
  output logic           res0_dvalid,
  input  logic           res0_dready,
  output logic [W:0]     res0_data,
  output logic           res0_eot,
  output logic           res1_dvalid,
  input  logic           res1_dready,
  output logic [W:0]     res1_data,
  output logic           res1_eot
);

  localparam int unsigned RW = W + 1;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          owner;
  logic          last;
  logic [RW-1:0] data_q;
  logic          eot_q;
`ifdef SUB_ARB_LOCK_EN
  logic          locked;
`endif

  logic          full;
  logic          drain_c;
  logic          can_accept_c;
  logic          grant_c;
  logic          gvalid_c;
  logic          accept_c;
  logic [2*W-1:0] sel_data_c;
  logic          sel_eot_c;
  logic [RW-1:0] a_ext_c;
  logic [RW-1:0] b_ext_c;
  logic [RW-1:0] diff_c;

  assign full         = (state == FULL);
  assign drain_c      = full & (owner ? res1_dready : res0_dready);
  assign can_accept_c = ~full | drain_c;

  // Round-robin pick; while locked, only the burst owner is considered.
  always_comb begin
    grant_c  = ~last;
    gvalid_c = 1'b0;
    if (req0_dvalid && req1_dvalid) begin
      grant_c  = ~last;
      gvalid_c = 1'b1;
    end else if (req0_dvalid) begin
      grant_c  = 1'b0;
      gvalid_c = 1'b1;
    end else if (req1_dvalid) begin
      grant_c  = 1'b1;
      gvalid_c = 1'b1;
    end
`ifdef SUB_ARB_LOCK_EN
    if (locked) begin
      grant_c  = last;
      gvalid_c = last ? req1_dvalid : req0_dvalid;
    end
`endif
  end

  // rst gates the handshake so dready drops the moment reset asserts.
  assign accept_c    = rst & can_accept_c & gvalid_c;
  assign req0_dready = accept_c & ~grant_c;
  assign req1_dready = accept_c & grant_c;

  assign sel_data_c = grant_c ? req1_data : req0_data;
  assign sel_eot_c  = grant_c ? req1_eot : req0_eot;

  always_comb begin
    if (SIGNED) begin
      a_ext_c = {sel_data_c[W-1], sel_data_c[W-1:0]};
      b_ext_c = {sel_data_c[2*W-1], sel_data_c[2*W-1:W]};
    end else begin
      a_ext_c = {1'b0, sel_data_c[W-1:0]};
      b_ext_c = {1'b0, sel_data_c[2*W-1:W]};
    end
  end

  assign diff_c = a_ext_c - b_ext_c;

  // Result register occupancy: a drain and a refill in the same cycle stays FULL.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept_c) state_nxt = FULL;
      FULL:    if (accept_c) state_nxt = FULL;
               else if (drain_c) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      eot_q  <= 1'b0;
      owner  <= 1'b0;
      last   <= 1'b1;
    end else if (accept_c) begin
      data_q <= diff_c;
      eot_q  <= sel_eot_c;
      owner  <= grant_c;
      last   <= grant_c;
    end
  end

`ifdef SUB_ARB_LOCK_EN
  // The lock owner is always the last grantee, so only a flag is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          locked <= 1'b0;
    else if (accept_c) locked <= ~sel_eot_c;
  end
`endif

  assign res0_dvalid = full & ~owner;
  assign res1_dvalid = full & owner;
  assign res0_data   = data_q;
  assign res1_data   = data_q;
  assign res0_eot    = eot_q;
  assign res1_eot    = eot_q;

endmodule

// File: tb/tb_sub_arb.sv
// Bench for sub_arb: unsigned and signed instances driven in parallel, checked
// against a transaction-level model; define SUB_ARB_LOCK_EN to cover burst locking.
module tb_sub_arb;

  localparam int unsigned W = 8;

`ifdef SUB_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           r0v, r1v, r0e, r1e, o0r, o1r;
  logic [2*W-1:0] r0d, r1d;

  logic       q0r_u, q1r_u, v0_u, v1_u, e0_u, e1_u;
  logic [W:0] d0_u, d1_u;
  logic       q0r_s, q1r_s, v0_s, v1_s, e0_s, e1_s;
  logic [W:0] d0_s, d1_s;

  sub_arb #(.W(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst),
    .req0_dvalid(r0v), .req0_dready(q0r_u), .req0_data(r0d), .req0_eot(r0e),
    .req1_dvalid(r1v), .req1_dready(q1r_u), .req1_data(r1d), .req1_eot(r1e),
    .res0_dvalid(v0_u), .res0_dready(o0r), .res0_data(d0_u), .res0_eot(e0_u),
    .res1_dvalid(v1_u), .res1_dready(o1r), .res1_data(d1_u), .res1_eot(e1_u)
  );

  sub_arb #(.W(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst),
    .req0_dvalid(r0v), .req0_dready(q0r_s), .req0_data(r0d), .req0_eot(r0e),
    .req1_dvalid(r1v), .req1_dready(q1r_s), .req1_data(r1d), .req1_eot(r1e),
    .res0_dvalid(v0_s), .res0_dready(o0r), .res0_data(d0_s), .res0_eot(e0_s),
    .res1_dvalid(v1_s), .res1_dready(o1r), .res1_data(d1_s), .res1_eot(e1_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one pending result plus arbitration history.
  bit         m_full, m_owner, m_last, m_lock, m_eot;
  logic [W-1:0] m_a, m_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    int ia, ib;
    if (sgn) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    return (W+1)'((ia - ib) & ((1 << (W + 1)) - 1));
  endfunction

  task automatic model_reset();
    m_full  = 1'b0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    m_lock  = 1'b0;
    m_eot   = 1'b0;
  endtask

  task automatic check_dut(input string n, input bit sgn,
                           input logic qa, input logic qb, input logic va, input logic vb,
                           input logic [W:0] da, input logic [W:0] db,
                           input logic ea, input logic eb, input bit xq0, input bit xq1);
    check({n, ".req0_dready"}, 32'(qa), 32'(xq0));
    check({n, ".req1_dready"}, 32'(qb), 32'(xq1));
    check({n, ".res0_dvalid"}, 32'(va), 32'(m_full && !m_owner));
    check({n, ".res1_dvalid"}, 32'(vb), 32'(m_full && m_owner));
    if (m_full) begin
      check({n, ".res_data"}, 32'(m_owner ? db : da), 32'(ref_diff(m_a, m_b, sgn)));
      check({n, ".res_eot"},  32'(m_owner ? eb : ea), 32'(m_eot));
    end
  endtask

  // One clock: check at negedge, advance the model at posedge, return 1 time unit later.
  task automatic cycle();
    bit g, gv, can, acc, drn;
    logic [2*W-1:0] sd;
    @(negedge clk);
    if (!rst) begin
      check_dut("u", 1'b0, q0r_u, q1r_u, v0_u, v1_u, d0_u, d1_u, e0_u, e1_u, 1'b0, 1'b0);
      check_dut("s", 1'b1, q0r_s, q1r_s, v0_s, v1_s, d0_s, d1_s, e0_s, e1_s, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      return;
    end
    can = !m_full || (m_owner ? o1r : o0r);
    g   = !m_last;
    gv  = r0v || r1v;
    if (r0v && !r1v) g = 1'b0;
    if (r1v && !r0v) g = 1'b1;
    if (LOCK && m_lock) begin
      g  = m_last;
      gv = m_last ? r1v : r0v;
    end
    acc = can && gv;
    drn = m_full && (m_owner ? o1r : o0r);
    check_dut("u", 1'b0, q0r_u, q1r_u, v0_u, v1_u, d0_u, d1_u, e0_u, e1_u, acc && !g, acc && g);
    check_dut("s", 1'b1, q0r_s, q1r_s, v0_s, v1_s, d0_s, d1_s, e0_s, e1_s, acc && !g, acc && g);
    @(posedge clk);
    if (acc) begin
      sd      = g ? r1d : r0d;
      m_full  = 1'b1;
      m_owner = g;
      m_a     = sd[W-1:0];
      m_b     = sd[2*W-1:W];
      m_eot   = g ? r1e : r0e;
      m_last  = g;
      m_lock  = !m_eot;
    end else if (drn) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic set_req0(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input bit e);
    r0v = v; r0d = {b, a}; r0e = e;
  endtask

  task automatic set_req1(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input bit e);
    r1v = v; r1d = {b, a}; r1e = e;
  endtask

  initial begin
    bit         prev_v1;
    logic [W:0] held;
    bit         exp_seq [4];

    model_reset();
    set_req0(1'b1, 8'h11, 8'h22, 1'b1);
    set_req1(1'b1, 8'h33, 8'h44, 1'b1);
    o0r = 1'b1; o1r = 1'b1;
    #2;
    cycle();
    cycle();
    rst = 1'b1;
    set_req1(1'b0, 8'h00, 8'h00, 1'b1);

    // Basic subtract, result on res0 only.
    set_req0(1'b1, 8'h05, 8'h03, 1'b1);
    cycle();
    check("basic.data", 32'(d0_u), 32'h002);
    check("basic.res1_dvalid", 32'(v1_u), 32'h0);

    // Wraparound, unsigned and signed.
    set_req0(1'b1, 8'h00, 8'h01, 1'b1);
    cycle();
    check("wrap.unsigned", 32'(d0_u), 32'h1FF);
    set_req0(1'b1, 8'h80, 8'h01, 1'b1);
    cycle();
    check("wrap.signed", 32'(d0_s), 32'h17F);
    check("wrap.unsigned80", 32'(d0_u), 32'h07F);
    set_req0(1'b0, 8'h00, 8'h00, 1'b1);
    cycle();

    // Continuous contention: alternate grants, no bubbles.
    prev_v1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_req0(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      set_req1(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      cycle();
      check("rr.no_bubble", 32'(v0_u ^ v1_u), 32'h1);
      if (i > 0) check("rr.alternate", 32'(v1_u), 32'(!prev_v1));
      prev_v1 = v1_u;
    end
    set_req0(1'b0, 8'h00, 8'h00, 1'b1);
    set_req1(1'b0, 8'h00, 8'h00, 1'b1);
    cycle();

    // Backpressure on res0 blocks both requesters and holds the result.
    set_req0(1'b1, 8'h40, 8'h0F, 1'b1);
    cycle();
    held = d0_u;
    set_req1(1'b1, 8'h12, 8'h34, 1'b1);
    o0r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.req0_dready", 32'(q0r_u), 32'h0);
      check("stall.req1_dready", 32'(q1r_u), 32'h0);
      cycle();
      check("stall.data", 32'(d0_u), 32'(held));
    end
    o0r = 1'b1;
    cycle();

    // Async reset while FULL drops everything immediately.
    set_req1(1'b0, 8'h00, 8'h00, 1'b1);
    set_req0(1'b1, 8'h09, 8'h01, 1'b1);
    o0r = 1'b0;
    cycle();
    check("rst.was_full", 32'(v0_u), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("rst.res0_dvalid", 32'(v0_u), 32'h0);
    check("rst.req0_dready", 32'(q0r_u), 32'h0);
    model_reset();
    o0r = 1'b1;
    cycle();
    rst = 1'b1;

    // Req0 burst of three against a continuously valid req1.
    exp_seq = LOCK ? '{1'b0, 1'b0, 1'b0, 1'b1} : '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      set_req0(1'b1, 8'($urandom), 8'($urandom), i == 2);
      set_req1(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      cycle();
      check("burst.owner", 32'(v1_u), 32'(exp_seq[i]));
      check("burst.full", 32'(v0_u | v1_u), 32'h1);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_req0(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
      set_req1(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
      o0r = ($urandom_range(0, 3) != 0);
      o1r = ($urandom_range(0, 3) != 0);
      cycle();
    end

    set_req0(1'b0, 8'h00, 8'h00, 1'b1);
    set_req1(1'b0, 8'h00, 8'h00, 1'b1);
    o0r = 1'b1; o1r = 1'b1;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
